// File: rtl/imem_boot_pkg.sv
// imem_boot_pkg: shared state encoding and default widths
// for the instruction-memory boot sequencer.
package imem_boot_pkg;

    localparam int ADDR_W_DEF = 8;
    localparam int DATA_W_DEF = 32;
    localparam int CNT_W_DEF  = 16;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_COMMIT = 3'd2,
        ST_RUN    = 3'd3,
        ST_HALT   = 3'd4,
        ST_ERR    = 3'd5
    } state_t;

endpackage

// File: rtl/imem_boot_if.sv
// imem_boot_if: program word stream (valid/ready).
// Ports: s_valid, s_data (source->ctrl), s_ready (ctrl->source).
interface imem_boot_if
    import imem_boot_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
);
    logic              s_valid;
    logic [DATA_W-1:0] s_data;
    logic              s_ready;

    modport master (
        output s_valid,
        output s_data,
        input  s_ready
    );

    modport slave (
        input  s_valid,
        input  s_data,
        output s_ready
    );
endinterface

// File: rtl/boot_run_timer.sv
// boot_run_timer: loadable saturating cycle counter for RUN.
// Ports: clk, rst, load/limit/unbounded (latched), en, expire.
module boot_run_timer
    import imem_boot_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] limit,
    input  logic             unbounded,
    input  logic             en,
    output logic             expire
);
    localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] lim_q;
    logic             unb_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt   <= '0;
            lim_q <= '0;
            unb_q <= 1'b0;
        end else if (load) begin
            cnt   <= '0;
            lim_q <= limit;
            unb_q <= unbounded;
        end else if (en && (cnt != '1)) begin
            cnt <= cnt + ONE;
        end
    end

    // cnt equals the index of the current RUN cycle, so the
    // last budgeted cycle is the one where cnt == limit-1.
    assign expire = en && !unb_q && (cnt == lim_q - ONE);
endmodule

// File: rtl/imem_boot_ctrl.sv
// imem_boot_ctrl: loads IM over a word stream with the core held
// in reset, then runs the core for run_cycles (0 = unbounded).
// Ports: CLK, RST, start, abort, len, run_cycles, s (stream slave),
// im_we/im_addr/im_wdata, core_rst, core_en, busy, done, err.
// Macro IMEM_BOOT_CHECKSUM_EN: a trailing checksum word is expected.
module imem_boot_ctrl
    import imem_boot_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int CNT_W  = CNT_W_DEF
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              start,
    input  logic              abort,
    input  logic [ADDR_W:0]   len,
    input  logic [CNT_W-1:0]  run_cycles,
    imem_boot_if.slave        s,
    output logic              im_we,
    output logic [ADDR_W-1:0] im_addr,
    output logic [DATA_W-1:0] im_wdata,
    output logic              core_rst,
    output logic              core_en,
    output logic              busy,
    output logic              done,
    output logic              err
);
    localparam logic [ADDR_W:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0] W_ONE = {{ADDR_W{1'b0}}, 1'b1};

    state_t          state;
    state_t          state_n;
    logic [ADDR_W:0] wcnt;
    logic [ADDR_W:0] len_q;
    logic            hs;
    logic            go;
    logic            wr;
    logic            last;
    logic            expire;

    assign hs = s.s_valid && s.s_ready;
    assign go = start && ((state == ST_IDLE) ||
                          (state == ST_HALT) ||
                          (state == ST_ERR));

`ifdef IMEM_BOOT_CHECKSUM_EN
    logic [DATA_W-1:0] sum;
    logic              sum_ok;

    // word index len is the checksum: checked, never written
    assign wr     = hs && (wcnt != len_q);
    assign last   = hs && (wcnt == len_q);
    assign sum_ok = (s.s_data == sum);
`else
    assign wr   = hs;
    assign last = hs && ((wcnt + W_ONE) == len_q);
`endif

    always_comb begin
        state_n = state;
        if (abort) begin
            state_n = ST_IDLE;
        end else begin
            unique case (state)
                ST_IDLE, ST_HALT, ST_ERR: begin
                    if (start) begin
                        unique case (1'b1)
                            (len > DEPTH): state_n = ST_ERR;
`ifndef IMEM_BOOT_CHECKSUM_EN
                            (len == '0):   state_n = ST_COMMIT;
`endif
                            default:       state_n = ST_LOAD;
                        endcase
                    end
                end
                ST_LOAD: begin
                    if (last) begin
`ifdef IMEM_BOOT_CHECKSUM_EN
                        state_n = sum_ok ? ST_COMMIT : ST_ERR;
`else
                        state_n = ST_COMMIT;
`endif
                    end
                end
                ST_COMMIT: state_n = ST_RUN;
                ST_RUN:    if (expire) state_n = ST_HALT;
                default:   state_n = ST_IDLE;
            endcase
        end
    end

    // Outputs are registered from the next state so they line
    // up with the state they describe.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state     <= ST_IDLE;
            wcnt      <= '0;
            len_q     <= '0;
            im_we     <= 1'b0;
            im_addr   <= '0;
            im_wdata  <= '0;
            s.s_ready <= 1'b0;
            core_rst  <= 1'b1;
            core_en   <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            state <= state_n;
            im_we <= wr && !abort;
            if (wr && !abort) begin
                im_addr  <= wcnt[ADDR_W-1:0];
                im_wdata <= s.s_data;
            end
            if (go && !abort) begin
                wcnt  <= '0;
                len_q <= len;
            end else if (hs && !abort) begin
                wcnt <= wcnt + W_ONE;
            end
            s.s_ready <= (state_n == ST_LOAD);
            core_rst  <= (state_n == ST_IDLE) ||
                         (state_n == ST_LOAD) ||
                         (state_n == ST_COMMIT) ||
                         (state_n == ST_ERR);
            core_en   <= (state_n == ST_RUN);
            busy      <= (state_n == ST_LOAD) ||
                         (state_n == ST_COMMIT) ||
                         (state_n == ST_RUN);
            done      <= (state_n == ST_HALT);
            err       <= (state_n == ST_ERR);
        end
    end

`ifdef IMEM_BOOT_CHECKSUM_EN
    always_ff @(posedge CLK) begin
        if (RST) begin
            sum <= '0;
        end else if (go) begin
            sum <= '0;
        end else if (wr) begin
            sum <= sum + s.s_data;
        end
    end
`endif

    boot_run_timer #(
        .CNT_W(CNT_W)
    ) u_timer (
        .clk       (CLK),
        .rst       (RST),
        .load      (go && !abort),
        .limit     (run_cycles),
        .unbounded (run_cycles == '0),
        .en        (state == ST_RUN),
        .expire    (expire)
    );
endmodule

// File: tb/tb_imem_boot_ctrl.sv
// tb_imem_boot_ctrl: directed + randomized bench for imem_boot_ctrl
// against a queue-based reference of expected IM writes and timing.
module tb_imem_boot_ctrl;
    localparam int AW = 8;
    localparam int DW = 32;
    localparam int CW = 16;

    logic          CLK = 1'b0;
    logic          RST = 1'b1;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic [AW:0]   len = '0;
    logic [CW-1:0] run_cycles = '0;
    logic          im_we;
    logic [AW-1:0] im_addr;
    logic [DW-1:0] im_wdata;
    logic          core_rst;
    logic          core_en;
    logic          busy;
    logic          done;
    logic          err;

    imem_boot_if #(.DATA_W(DW)) s ();

    imem_boot_ctrl #(
        .ADDR_W(AW),
        .DATA_W(DW),
        .CNT_W (CW)
    ) dut (
        .CLK        (CLK),
        .RST        (RST),
        .start      (start),
        .abort      (abort),
        .len        (len),
        .run_cycles (run_cycles),
        .s          (s),
        .im_we      (im_we),
        .im_addr    (im_addr),
        .im_wdata   (im_wdata),
        .core_rst   (core_rst),
        .core_en    (core_en),
        .busy       (busy),
        .done       (done),
        .err        (err)
    );

    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    // observed IM writes
    int            wa[$];
    logic [DW-1:0] wd[$];
    int            wc[$];
    always @(negedge CLK) begin
        if (im_we === 1'b1) begin
            wa.push_back(int'(im_addr));
            wd.push_back(im_wdata);
            wc.push_back(cyc);
        end
    end

    // reference: program words, handshake cycles, expected totals
    logic [DW-1:0] prog[$];
    int            hs[$];
    int            st_cyc;
    int            tot;
    bit            rst_bad;
    int            n_run = 0;
    int            n_fail = 0;

    task automatic tick;
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_run++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic fill(input int n);
        prog.delete();
        repeat (n) prog.push_back($urandom);
    endtask

    // mode: 0 back-to-back, 1 toggle 1/0, 2 random valid
    task automatic boot(input int n, input int rc, input int mode,
                        input int abort_at, input logic [DW-1:0] delta);
        int            sent;
        int            g;
        bit            ab;
        logic [DW-1:0] sum;
        hs.delete();
        wa.delete();
        wd.delete();
        wc.delete();
        rst_bad = 0;
        sum = '0;
        foreach (prog[i]) sum = sum + prog[i];
        tot = n;
`ifdef IMEM_BOOT_CHECKSUM_EN
        tot = n + 1;
`endif
        len = (AW+1)'(n);
        run_cycles = CW'(rc);
        start = 1'b1;
        st_cyc = cyc;
        tick;
        start = 1'b0;
        sent = 0;
        g = 0;
        ab = 0;
        while (sent < tot && g < 4000) begin
            unique case (mode)
                0:       s.s_valid = 1'b1;
                1:       s.s_valid = (g % 2 == 0);
                default: s.s_valid = 1'($urandom_range(0, 1));
            endcase
            s.s_data = (sent < n) ? prog[sent] : sum + delta;
            ab = (sent == abort_at) && s.s_valid && s.s_ready;
            abort = ab;
            if (core_rst !== 1'b1) rst_bad = 1;
            if (s.s_valid && s.s_ready) begin
                if (sent < n && !ab) hs.push_back(cyc);
                sent++;
            end
            tick;
            g++;
            if (ab) break;
        end
        s.s_valid = 1'b0;
        abort = 1'b0;
        chk("stream_in_bound", 64'(g < 4000), 64'd1);
        chk("core_rst_in_load", 64'(rst_bad), 64'd0);
    endtask

    task automatic run_check(input int rc, input int exp_lat);
        int g;
        int n_en;
        g = 0;
        while (core_en !== 1'b1 && g < 1000) begin
            tick;
            g++;
        end
        chk("en_seen", 64'(core_en), 64'd1);
        if (exp_lat >= 0) chk("en_latency", 64'(cyc - st_cyc), 64'(exp_lat));
        n_en = 0;
        g = 0;
        while (done !== 1'b1 && g < rc + 20) begin
            if (core_en === 1'b1) n_en++;
            tick;
            g++;
        end
        chk("run_len", 64'(n_en), 64'(rc));
        chk("halt_done", 64'(done), 64'd1);
        chk("halt_en", 64'(core_en), 64'd0);
        chk("halt_rst", 64'(core_rst), 64'd0);
        chk("halt_busy", 64'(busy), 64'd0);
    endtask

    task automatic check_writes(input int n);
        chk("wr_count", 64'(wa.size()), 64'(n));
        for (int i = 0; i < n && i < wa.size() && i < hs.size(); i++) begin
            chk($sformatf("wr_addr%0d", i), 64'(wa[i]), 64'(i));
            chk($sformatf("wr_data%0d", i), 64'(wd[i]), 64'(prog[i]));
            chk($sformatf("wr_cyc%0d", i), 64'(wc[i]), 64'(hs[i] + 1));
        end
    endtask

    initial begin
        int n;
        int rc;
        bit en_drop;
        s.s_valid = 1'b0;
        s.s_data = '0;

        // reset values
        tick;
        tick;
        chk("rst_s_ready", 64'(s.s_ready), 64'd0);
        chk("rst_im_we", 64'(im_we), 64'd0);
        chk("rst_im_addr", 64'(im_addr), 64'd0);
        chk("rst_im_wdata", 64'(im_wdata), 64'd0);
        chk("rst_core_rst", 64'(core_rst), 64'd1);
        chk("rst_core_en", 64'(core_en), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_err", 64'(err), 64'd0);
        RST = 1'b0;
        tick;

        // basic boot
        fill(14);
        boot(14, 15, 0, -1, '0);
        run_check(15, tot + 2);
        check_writes(14);

        // stalled stream
        fill(3);
        boot(3, 4, 1, -1, '0);
        run_check(4, -1);
        check_writes(3);

        // abort on handshake of word 4
        fill(8);
        boot(8, 5, 0, 4, '0);
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_core_rst", 64'(core_rst), 64'd1);
        chk("abort_im_we", 64'(im_we), 64'd0);
        tick;
        tick;
        check_writes(4);

        // len = 0
        fill(0);
        boot(0, 3, 0, -1, '0);
        run_check(3, tot + 2);
        check_writes(0);

        // len = 257 -> ERR
        wa.delete();
        len = (AW+1)'(257);
        run_cycles = CW'(5);
        start = 1'b1;
        tick;
        start = 1'b0;
        chk("err_err", 64'(err), 64'd1);
        chk("err_core_rst", 64'(core_rst), 64'd1);
        chk("err_busy", 64'(busy), 64'd0);
        chk("err_s_ready", 64'(s.s_ready), 64'd0);
        repeat (4) tick;
        chk("err_no_write", 64'(wa.size()), 64'd0);
        abort = 1'b1;
        tick;
        abort = 1'b0;
        chk("err_abort_clr", 64'(err), 64'd0);

        // len = 256
        fill(256);
        boot(256, 2, 0, -1, '0);
        run_check(2, tot + 2);
        check_writes(256);
        chk("last_addr", 64'(wa[wa.size()-1]), 64'd255);

        // randomized boots with random stalls, chained from HALT
        repeat (4) begin
            n = $urandom_range(1, 20);
            rc = $urandom_range(1, 40);
            fill(n);
            boot(n, rc, 2, -1, '0);
            run_check(rc, -1);
            check_writes(n);
        end

`ifdef IMEM_BOOT_CHECKSUM_EN
        prog.delete();
        prog.push_back(32'd1);
        prog.push_back(32'd2);
        prog.push_back(32'd3);
        boot(3, 5, 0, -1, '0);
        run_check(5, tot + 2);
        check_writes(3);
        boot(3, 5, 0, -1, 32'd1);
        chk("cks_err", 64'(err), 64'd1);
        chk("cks_core_rst", 64'(core_rst), 64'd1);
        tick;
        check_writes(3);
`endif

        // unbounded run, start ignored, then abort
        fill(2);
        boot(2, 0, 0, -1, '0);
        n = 0;
        while (core_en !== 1'b1 && n < 100) begin
            tick;
            n++;
        end
        en_drop = 0;
        for (int i = 0; i < 70000; i++) begin
            if (i == 1000) begin
                len = (AW+1)'(5);
                start = 1'b1;
            end else begin
                start = 1'b0;
            end
            if (core_en !== 1'b1) en_drop = 1;
            tick;
        end
        start = 1'b0;
        chk("unb_en_held", 64'(en_drop), 64'd0);
        chk("unb_core_en", 64'(core_en), 64'd1);
        chk("unb_done", 64'(done), 64'd0);
        check_writes(2);
        abort = 1'b1;
        tick;
        abort = 1'b0;
        chk("unb_abort_en", 64'(core_en), 64'd0);
        chk("unb_abort_rst", 64'(core_rst), 64'd1);
        chk("unb_abort_busy", 64'(busy), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule

// File: doc/imem_boot_ctrl.md
# imem_boot_ctrl

Boot sequencer for the single-cycle core. It loads a program into instruction memory (IM) over a valid/ready word stream while holding the core in reset. It then releases the core for a bounded number of cycles and halts it, signalling completion. It sits between the host-side program source and the `Top` core's IM write port, core reset and core clock-enable.

## Interface
Parameters:
- `ADDR_W`, 8: IM word-address width; IM depth is 2**ADDR_W words.
- `DATA_W`, 32: instruction word width.
- `CNT_W`, 16: width of the run-cycle budget.

Ports:
- `CLK`, in, 1: single clock; all state changes on the rising edge.
- `RST`, in, 1: synchronous, active-high reset.
- `start`, in, 1: one-cycle pulse that begins a boot; sampled only in IDLE, HALT and ERR.
- `abort`, in, 1: forces return to IDLE from any state.
- `len`, in, ADDR_W+1: number of program words; latched on `start`.
- `run_cycles`, in, CNT_W: core run budget; latched on `start`; 0 means unbounded.
- `s_valid`, in, 1: stream word valid.
- `s_data`, in, DATA_W: stream word.
- `s_ready`, out, 1: controller accepts a word.
- `im_we`, out, 1: IM write enable (registered).
- `im_addr`, out, ADDR_W: IM word address (registered).
- `im_wdata`, out, DATA_W: IM write data (registered).
- `core_rst`, out, 1: core reset (active-high); also clears PC.
- `core_en`, out, 1: core clock-enable; when low, PC and register file hold.
- `busy`, out, 1: high in LOAD, COMMIT and RUN.
- `done`, out, 1: high in HALT.
- `err`, out, 1: high in ERR.

## Operation
- States: IDLE, LOAD, COMMIT, RUN, HALT, ERR.
- **Reset values:** state IDLE; `s_ready`=0, `im_we`=0, `im_addr`=0, `im_wdata`=0, `core_rst`=1, `core_en`=0, `busy`=0, `done`=0, `err`=0.
- **IDLE/HALT/ERR + `start`:**
  - `len` > 2**ADDR_W: go to ERR.
  - `len`=0: go to COMMIT (no load phase).
  - Otherwise: go to LOAD with the word counter cleared.
- **LOAD:**
  - `s_ready`=1 and `core_rst`=1.
  - Each handshake (`s_valid`&&`s_ready`) produces, the next cycle, `im_we`=1, `im_addr`=word counter, `im_wdata`=`s_data`; the counter then increments.
  - On the handshake of word `len`-1, go to COMMIT. `s_ready` drops in the same cycle the state leaves LOAD.
  - Stalls (`s_valid`=0) may last any length.
- **COMMIT:** exactly one cycle.
  - The final IM write completes here.
  - `core_rst` stays 1, `s_ready`=0.
  - Go to RUN.
- **RUN:**
  - `core_rst`=0, `core_en`=1.
  - The run counter counts cycles spent in RUN.
  - After exactly `run_cycles` RUN cycles, go to HALT. If `run_cycles`=0, stay in RUN until `abort`.
- **HALT:**
  - `core_en`=0 and `core_rst`=0, so architectural state is preserved for inspection.
  - `done`=1.
  - Stays in HALT until `start` or `abort`.
- **ERR:** `core_rst`=1, `err`=1; leave on `start` or `abort`.
- **`abort`:**
  - Has priority over everything, including a simultaneous `start` or handshake.
  - Next cycle: IDLE, `core_rst`=1, `im_we`=0.
  - A word handshaken in the abort cycle is discarded (not written).
- **`start` in LOAD, COMMIT or RUN:** ignored.
- **Counter widths:**
  - The word counter is ADDR_W+1 bits and never wraps, because `len` ≤ 2**ADDR_W.
  - The run counter is CNT_W bits and saturates; it never wraps in unbounded mode.

## Timing
- Write latency: handshake in cycle n gives `im_we` in cycle n+1.
- Peak throughput is one word per cycle.
- Boot latency from `start` to the first `core_en`=1 is `len`+2 cycles with no stalls.
- `done` rises exactly `run_cycles` cycles after the first `core_en`=1 cycle.
- All outputs are registered; none depends combinationally on inputs.

## Configuration
- Macro: `IMEM_BOOT_CHECKSUM_EN`.
- **Defined:**
  - LOAD accepts `len`+1 words.
  - The extra final word is a checksum, compared with the mod-2**DATA_W sum of the `len` data words.
  - The checksum word is never written to IM.
  - On mismatch, go to ERR instead of COMMIT.
  - With `len`=0, one word equal to 0 is still expected.
- **Undefined:** exactly `len` words are accepted and no check is made.

## Structure
- Package `imem_boot_pkg` holds:
  - the state encoding (a 3-bit enum: IDLE=0, LOAD=1, COMMIT=2, RUN=3, HALT=4, ERR=5);
  - default width constants for ADDR_W, DATA_W and CNT_W.
- One sub-module, `boot_run_timer`: a loadable saturating cycle counter with `load`, `en`, `unbounded` and `expire` ports, used by RUN.
- The FSM, word counter and IM write registers stay in `imem_boot_ctrl`.

## Test plan
- **Basic boot:** `len`=14, `run_cycles`=15, the fourteen-instruction program streamed back to back → IM[0..13] written on consecutive cycles; `core_en` high for exactly 15 cycles; then `done`=1 and the core's x16=123, x15=0.
- **Stalled stream:** `len`=3, `s_valid` toggled 1/0 → three writes to addresses 0, 1, 2, each one cycle after its handshake; no write occurs in stall cycles.
- **Abort mid-load:** `len`=8, `abort` asserted on the handshake of word 4 → IDLE next cycle; only addresses 0–3 are written; `core_rst`=1 throughout.
- **Edge lengths:**
  - `len`=0 → COMMIT then RUN after 2 cycles.
  - `len`=257 with ADDR_W=8 → ERR, `err`=1, no IM write.
  - `len`=256 → last write lands at address 255.
- **Unbounded run:** `run_cycles`=0 → `core_en` still high after 70000 cycles; `start` is ignored; `abort` → IDLE.
- **Checksum (macro defined):** words 1, 2, 3 plus checksum 6 → RUN. Same words plus checksum 7 → ERR, `core_rst` held at 1, only 3 IM writes.
